// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART blocks.
//   - uart_state_t : receiver FSM state encoding (2 bits)
//   - DEF_*        : default frame and oversampling parameters
//   - clogb2       : width needed to count 0..value-1 (minimum 1 bit)
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    localparam int DEF_NB_DATA    = 8;
    localparam int DEF_SB_TICK    = 16;
    localparam int DEF_OVERSAMPLE = 16;

    // Number of bits needed to hold the values 0..value-1.
    function automatic int clogb2(input int value);
        int width;
        int v;
        width = 0;
        for (v = value - 1; v > 0; v = v >> 1) begin
            width = width + 1;
        end
        if (width == 0) begin
            width = 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous input.
//   i_clk   : destination clock
//   i_reset : synchronous, active-high; both flops load RESET_VAL
//   i_d     : asynchronous input
//   o_q     : synchronized output, two clocks behind i_d
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic meta;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            meta <= RESET_VAL;
            o_q  <= RESET_VAL;
        end else begin
            meta <= i_d;
            o_q  <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver.
//   i_clk       : system clock
//   i_reset     : synchronous, active-high; aborts any frame in progress
//   i_tick      : oversampling strobe, OVERSAMPLE ticks per bit period
//   i_rx        : raw serial line, idle high, asynchronous to i_clk
//   o_data      : last received byte, held until the next completed frame
//   o_rx_done   : one-cycle pulse when a frame completes
//   o_frame_err : one-cycle pulse alongside o_rx_done when the stop sample is 0
//   o_state     : current FSM state, for observation only
//
// Handshake: o_rx_done is a valid-only strobe with no ready/backpressure.
// o_data is valid in the o_rx_done cycle and stays stable until the next
// o_rx_done; a consumer that has not latched it by then loses the byte.
//
// OVERSAMPLE must be even and >= 4 so that the mid-start-bit check lands
// on a tick strictly inside the start bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int NB_DATA    = DEF_NB_DATA,
    parameter int SB_TICK    = DEF_SB_TICK,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_tick,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rx_done,
    output logic               o_frame_err,
    output uart_state_t        o_state
);

    localparam int S_MAX = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
    localparam int S_W   = clogb2(S_MAX);
    localparam int N_W   = clogb2(NB_DATA);

    localparam logic [S_W-1:0] S_ONE       = S_W'(1);
    localparam logic [S_W-1:0] S_HALF_LAST = S_W'(OVERSAMPLE / 2 - 1);
    localparam logic [S_W-1:0] S_BIT_LAST  = S_W'(OVERSAMPLE - 1);
    localparam logic [S_W-1:0] S_STOP_LAST = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0] N_ONE       = N_W'(1);
    localparam logic [N_W-1:0] N_LAST      = N_W'(NB_DATA - 1);

    logic rx_s;

    uart_state_t        state, state_next;
    logic [S_W-1:0]     s, s_next;
    logic [N_W-1:0]     n, n_next;
    logic [NB_DATA-1:0] b, b_next;
    logic [NB_DATA-1:0] data_next;
    logic               done_next;
    logic               ferr_next;

    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_sync_rx (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_d    (i_rx),
        .o_q    (rx_s)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= ST_IDLE;
            s           <= '0;
            n           <= '0;
            b           <= '0;
            o_data      <= '0;
            o_rx_done   <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            state       <= state_next;
            s           <= s_next;
            n           <= n_next;
            b           <= b_next;
            o_data      <= data_next;
            o_rx_done   <= done_next;
            o_frame_err <= ferr_next;
        end
    end

    always_comb begin
        state_next = state;
        s_next     = s;
        n_next     = n;
        b_next     = b;
        data_next  = o_data;
        done_next  = 1'b0;
        ferr_next  = 1'b0;

        case (state)
            // Start-edge detection runs every clock, not only on ticks, so
            // the START tick count is referenced to the edge as closely as
            // the synchronizer allows.
            ST_IDLE: begin
                if (!rx_s) begin
                    state_next = ST_START;
                    s_next     = '0;
                end
            end

            // Re-check the line at mid-start-bit; a high line means the
            // falling edge was a glitch and is dropped silently.
            ST_START: begin
                if (i_tick) begin
                    if (s == S_HALF_LAST) begin
                        if (!rx_s) begin
                            state_next = ST_DATA;
                            s_next     = '0;
                            n_next     = '0;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end else begin
                        s_next = s + S_ONE;
                    end
                end
            end

            // From mid-start-bit, each full bit period lands on mid-bit.
            ST_DATA: begin
                if (i_tick) begin
                    if (s == S_BIT_LAST) begin
                        s_next = '0;
                        b_next = {rx_s, b[NB_DATA-1:1]};
                        if (n == N_LAST) begin
                            state_next = ST_STOP;
                        end else begin
                            n_next = n + N_ONE;
                        end
                    end else begin
                        s_next = s + S_ONE;
                    end
                end
            end

            // The byte is handed over even when the stop sample is low.
            ST_STOP: begin
                if (i_tick) begin
                    if (s == S_STOP_LAST) begin
                        state_next = ST_IDLE;
                        data_next  = b;
                        done_next  = 1'b1;
                        ferr_next  = ~rx_s;
                    end else begin
                        s_next = s + S_ONE;
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign o_state = state;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx with a 4-clock tick generator.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CLKS_PER_TICK = 4;

    logic        i_clk;
    logic        i_reset;
    logic        i_tick;
    logic        i_rx;
    logic [7:0]  o_data;
    logic        o_rx_done;
    logic        o_frame_err;
    uart_state_t o_state;

    int tests_run = 0;
    int tests_failed = 0;
    int done_cnt = 0;
    int exp_done = 0;

    // Scoreboard entries are {frame_err, data}.
    logic [8:0] exp_q[$];

    uart_rx #(
        .NB_DATA   (8),
        .SB_TICK   (16),
        .OVERSAMPLE(16)
    ) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_tick     (i_tick),
        .i_rx       (i_rx),
        .o_data     (o_data),
        .o_rx_done  (o_rx_done),
        .o_frame_err(o_frame_err),
        .o_state    (o_state)
    );

    // ---------------- clock / reset / tick generator ----------------
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    logic [1:0] tick_cnt = 2'd0;
    initial i_tick = 1'b0;
    always @(posedge i_clk) begin
        tick_cnt <= tick_cnt + 2'd1;
        i_tick   <= (tick_cnt == 2'd2);
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge i_clk) begin
        if (o_rx_done) begin
            done_cnt = done_cnt + 1;
            tests_run = tests_run + 1;
            if (exp_q.size() == 0) begin
                tests_failed = tests_failed + 1;
                $error("FAIL unexpected_done got data=%h ferr=%b", o_data, o_frame_err);
            end else begin
                logic [8:0] exp;
                exp = exp_q.pop_front();
                assert ({o_frame_err, o_data} === exp) else begin
                    tests_failed = tests_failed + 1;
                    $error("FAIL frame got {ferr,data}=%h expected %h", {o_frame_err, o_data}, exp);
                end
            end
        end
        if (o_frame_err) begin
            tests_run = tests_run + 1;
            assert (o_rx_done === 1'b1) else begin
                tests_failed = tests_failed + 1;
                $error("FAIL ferr_without_done got done=%b expected 1", o_rx_done);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run = tests_run + 1;
        assert (got === exp) else begin
            tests_failed = tests_failed + 1;
            $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input logic v, input int nticks);
        i_rx = v;
        repeat (nticks * CLKS_PER_TICK) @(negedge i_clk);
    endtask

    // start_ticks != 16 shifts every later edge of the frame.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int start_ticks);
        drive_bit(1'b0, start_ticks);
        for (int i = 0; i < 8; i++) begin
            drive_bit(d[i], 16);
        end
        drive_bit(stop, 16);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        i_rx    = 1'b1;
        i_reset = 1'b1;
        repeat (4) @(negedge i_clk);
        check("reset_data",  32'(o_data), 32'h00);
        check("reset_done",  32'(o_rx_done), 32'h0);
        check("reset_ferr",  32'(o_frame_err), 32'h0);
        check("reset_state", 32'(o_state), 32'(ST_IDLE));
        i_reset = 1'b0;
        drive_bit(1'b1, 20);

        // Single clean frame.
        exp_q.push_back({1'b0, 8'h55});
        send_frame(8'h55, 1'b1, 16);
        drive_bit(1'b1, 16);
        exp_done = exp_done + 1;
        check("f55_count", 32'(done_cnt), 32'(exp_done));
        check("f55_data",  32'(o_data), 32'h55);
        check("f55_done_low", 32'(o_rx_done), 32'h0);

        // Back-to-back frames, no idle gap between them.
        exp_q.push_back({1'b0, 8'h00});
        exp_q.push_back({1'b0, 8'hFF});
        send_frame(8'h00, 1'b1, 16);
        send_frame(8'hFF, 1'b1, 16);
        drive_bit(1'b1, 16);
        exp_done = exp_done + 2;
        check("b2b_count", 32'(done_cnt), 32'(exp_done));
        check("b2b_data",  32'(o_data), 32'hFF);

        // Start glitch: rejected at mid-start-bit.
        drive_bit(1'b0, 4);
        drive_bit(1'b1, 40);
        check("glitch_count", 32'(done_cnt), 32'(exp_done));
        check("glitch_state", 32'(o_state), 32'(ST_IDLE));
        check("glitch_data_held", 32'(o_data), 32'hFF);
        exp_q.push_back({1'b0, 8'hA3});
        send_frame(8'hA3, 1'b1, 16);
        drive_bit(1'b1, 16);
        exp_done = exp_done + 1;
        check("a3_count", 32'(done_cnt), 32'(exp_done));
        check("a3_data",  32'(o_data), 32'hA3);

        // Reset in the middle of data bit 4 of 0xC7 (bit 4 is 0).
        drive_bit(1'b0, 16);
        for (int i = 0; i < 4; i++) begin
            drive_bit(1'(8'hC7 >> i), 16);
        end
        drive_bit(1'b0, 8);
        check("pre_reset_state", 32'(o_state), 32'(ST_DATA));
        i_reset = 1'b1;
        i_rx    = 1'b1;
        @(negedge i_clk);
        i_reset = 1'b0;
        check("midreset_data",  32'(o_data), 32'h00);
        check("midreset_state", 32'(o_state), 32'(ST_IDLE));
        drive_bit(1'b1, 40);
        check("midreset_count", 32'(done_cnt), 32'(exp_done));
        check("midreset_state_idle", 32'(o_state), 32'(ST_IDLE));
        exp_q.push_back({1'b0, 8'h81});
        send_frame(8'h81, 1'b1, 16);
        drive_bit(1'b1, 16);
        exp_done = exp_done + 1;
        check("f81_count", 32'(done_cnt), 32'(exp_done));
        check("f81_data",  32'(o_data), 32'h81);

        // Edge jitter: all edges after the start edge +5 then -5 ticks.
        exp_q.push_back({1'b0, 8'h96});
        send_frame(8'h96, 1'b1, 21);
        drive_bit(1'b1, 16);
        exp_done = exp_done + 1;
        check("jit_p5_count", 32'(done_cnt), 32'(exp_done));
        check("jit_p5_data",  32'(o_data), 32'h96);
        exp_q.push_back({1'b0, 8'h96});
        send_frame(8'h96, 1'b1, 11);
        drive_bit(1'b1, 16);
        exp_done = exp_done + 1;
        check("jit_m5_count", 32'(done_cnt), 32'(exp_done));
        check("jit_m5_data",  32'(o_data), 32'h96);

        // Framing error: stop bit driven low, byte still delivered.
        exp_q.push_back({1'b1, 8'h3C});
        send_frame(8'h3C, 1'b0, 16);
        drive_bit(1'b1, 20);
        exp_done = exp_done + 1;
        check("ferr_count", 32'(done_cnt), 32'(exp_done));
        check("ferr_data",  32'(o_data), 32'h3C);

        check("sb_queue_empty", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver that deserializes an asynchronous serial line into parallel bytes, using the oversampling tick from the baud-rate generator (16 ticks per bit period). It sits between the board RX pin and the downstream consumer (interface/loopback logic). For each received frame it emits a one-cycle done pulse with the byte, plus a framing-error flag.

## Interface
- NB_DATA, 8, data bits per frame (LSB first)
- SB_TICK, 16, ticks in the stop-bit period (16 = 1 stop bit, 32 = 2 stop bits)
- OVERSAMPLE, 16, ticks per bit period; must be even and ≥ 4
- i_clk  in  1  system clock
- i_reset  in  1  reset; synchronous, active-high; clock i_clk
- i_tick  in  1  one-cycle oversampling strobe from the baud-rate generator
- i_rx  in  1  raw serial line, idle high, asynchronous to i_clk
- o_data  out  NB_DATA  last received byte; held until the next completed frame
- o_rx_done  out  1  one-cycle pulse, frame completed; o_data valid in the same cycle
- o_frame_err  out  1  one-cycle pulse together with o_rx_done when the stop-bit sample is 0

## Operation
- i_rx passes through a 2-FF synchronizer (reset value 1). All decisions use the synchronized value rx_s.
- Tick counter s is 0..max(OVERSAMPLE, SB_TICK)-1. Bit counter n is 0..NB_DATA-1. Shift register b is NB_DATA wide.
- The FSM only advances on cycles with i_tick=1. The only exception is IDLE.
- IDLE:
  - rx_s=0 (sampled every clock, tick-independent) → START, s=0.
- START, on each tick:
  - s<OVERSAMPLE/2-1 → s++.
  - s=OVERSAMPLE/2-1 and rx_s=0 → DATA, s=0, n=0. This is mid-start-bit.
  - s=OVERSAMPLE/2-1 and rx_s=1 → IDLE. A glitch is rejected, with no outputs.
- DATA, on each tick:
  - s<OVERSAMPLE-1 → s++.
  - s=OVERSAMPLE-1 → b = {rx_s, b[NB_DATA-1:1]}, s=0.
  - At that point, n=NB_DATA-1 → STOP, else n++.
- STOP, on each tick:
  - s<SB_TICK-1 → s++.
  - s=SB_TICK-1 → o_data=b, o_rx_done=1, o_frame_err=~rx_s, next state IDLE.
- The byte is delivered even on a framing error.
- Reset values:
  - State IDLE; s, n, b = 0.
  - o_data=0, o_rx_done=0, o_frame_err=0; synchronizer FFs = 1.
- Reset mid-frame: the receiver aborts immediately with no done pulse. o_data returns to 0.
- No flow control or overrun detection. The consumer must latch o_data on o_rx_done before the next frame completes. The data is held for at least one full frame time.
- Break condition (line held low): a frame with data 0 completes with o_frame_err=1. The FSM returns to IDLE, sees rx_s=0, and starts a new frame. This repeats each frame time; it is accepted behaviour.

## Timing
- Synchronizer latency: 2 clocks from an i_rx edge to rx_s.
- Bit sampling happens at the mid-bit tick: OVERSAMPLE/2 + k·OVERSAMPLE ticks after the start edge is detected, for k = 1..NB_DATA.
- o_rx_done and o_frame_err are registered and asserted in the clock after the final stop tick. They are high for exactly one cycle.
- o_data updates in the same edge as o_rx_done.
- Back-to-back frames: IDLE accepts a new start edge in the first clock after done. No dead time is required beyond the stop bit.
- Tolerance: ±(OVERSAMPLE/2-1)/OVERSAMPLE of one bit accumulated across the frame, from sampling at the centre.

## Structure
- Shared package/header uart_pkg:
  - FSM state encodings IDLE/START/DATA/STOP (2 bits).
  - Default NB_DATA/SB_TICK/OVERSAMPLE values.
  - The clogb2 helper used to size s and n.
- One natural sub-module: sync_2ff (parameterized reset value, default 1). It is reused by other pin-facing blocks.
- The baud-rate generator stays external; its o_tick drives i_tick.

## Test plan
- Bench setup: baud generator with NCYCLES_PER_TICK=4 and defaults; the serial driver holds each bit 16 ticks.
- Frame 0x55 with a valid stop → exactly one o_rx_done pulse, o_data=0x55, o_frame_err=0. No other done pulses.
- Frames 0x00 then 0xFF back-to-back, no idle gap → two done pulses, o_data 0x00 then 0xFF, both with frame_err=0.
- Start glitch: i_rx low for 4 ticks, then high for 40 ticks → no o_rx_done. FSM is in IDLE, and a following frame 0xA3 is received as 0xA3.
- Frame 0x3C with the stop bit driven 0 → o_rx_done=1 and o_frame_err=1 in the same cycle, o_data=0x3C.
- i_reset pulsed during data bit 4 of frame 0xC7 → no done pulse; o_data=0; next frame 0x81 is received correctly.
- Edge jitter: every bit edge of frame 0x96 shifted +5 ticks, then repeated at −5 ticks → o_data=0x96 in both runs.
